pmt_action_fetch: RTL and testbench

PMT_ACTION_FETCH -- requirements
Module: pmt_action_fetch

---
 rtl/pmt_action_fetch.sv | 169 ++++++++++++++++
 tb/tb_pmt_action_fetch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pmt_action_fetch.sv
`default_nettype none
// ============================================================================
// Module   : pmt_action_fetch
// Purpose  : TCAM result -> action RAM lookup with show-ahead output FIFO,
//            skid-based in_ready and saturating statistics.
// Revision : 1.0  initial release
// ============================================================================
module pmt_action_fetch #(
   parameter int ADDR_WIDTH   = 5,
   parameter int DEPTH        = 32,
   parameter int ACTION_WIDTH = 64,
   parameter int TAG_WIDTH    = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int SKID         = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic                    match_found,
   input  logic [ADDR_WIDTH-1:0]   match_addr,
   input  logic [TAG_WIDTH-1:0]    in_tag,
   output logic                    in_ready,
   input  logic                    cfg_wr_en,
   input  logic [ADDR_WIDTH-1:0]   cfg_wr_addr,
   input  logic [ACTION_WIDTH-1:0] cfg_wr_data,
   input  logic                    cfg_def_wr_en,
   input  logic [ACTION_WIDTH-1:0] cfg_def_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ACTION_WIDTH-1:0] out_action,
   output logic                    out_hit,
   output logic [ADDR_WIDTH-1:0]   out_addr,
   output logic [TAG_WIDTH-1:0]    out_tag,
   output logic [15:0]             drop_cnt,
   output logic [15:0]             hit_cnt,
   output logic [15:0]             miss_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FIFO_DEPTH);

   logic [ACTION_WIDTH-1:0] r_ram [DEPTH];

   logic [ACTION_WIDTH-1:0] r_s2_data;
   logic                    r_s2_valid;
   logic                    r_s2_hit;
   logic [ADDR_WIDTH-1:0]   r_s2_addr;
   logic [TAG_WIDTH-1:0]    r_s2_tag;
   logic [ACTION_WIDTH-1:0] r_def;

   logic [ACTION_WIDTH-1:0] r_fifo_action [FIFO_DEPTH];
   logic                    r_fifo_hit    [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]   r_fifo_addr   [FIFO_DEPTH];
   logic [TAG_WIDTH-1:0]    r_fifo_tag    [FIFO_DEPTH];
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [CNT_W-1:0]        r_count;

   logic [15:0]             r_drop_cnt;
   logic [15:0]             r_hit_cnt;
   logic [15:0]             r_miss_cnt;

   logic                    w_full;
   logic                    w_pop;
   logic                    w_push_ok;
   logic                    w_drop;
   logic [ACTION_WIDTH-1:0] w_entry_action;
   logic [31:0]             w_used;

   // Action RAM and its read register: no reset, and the read samples the
   // pre-write contents so a same-cycle config write returns the old word.
   always_ff @(posedge clk) begin
      if (cfg_wr_en)
         r_ram[cfg_wr_addr] <= cfg_wr_data;
      if (in_valid)
         r_s2_data <= r_ram[match_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_hit   <= 1'b0;
         r_s2_addr  <= '0;
         r_s2_tag   <= '0;
         r_def      <= '0;
      end else begin
         r_s2_valid <= in_valid;
         if (in_valid) begin
            r_s2_hit  <= match_found;
            r_s2_addr <= match_found ? match_addr : '0;
            r_s2_tag  <= in_tag;
         end
         if (cfg_def_wr_en)
            r_def <= cfg_def_data;
      end
   end

   // The default register is read before its update lands, so a default
   // write during S2 only affects later misses.
   assign w_entry_action = r_s2_hit ? r_s2_data : r_def;

   assign w_full    = (r_count == C_FULL);
   assign out_valid = (r_count != '0);
   assign w_pop     = out_valid && out_ready;
   assign w_push_ok = r_s2_valid && (!w_full || w_pop);
   assign w_drop    = r_s2_valid && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_fifo_action[r_wr_ptr] <= w_entry_action;
         r_fifo_hit[r_wr_ptr]    <= r_s2_hit;
         r_fifo_addr[r_wr_ptr]   <= r_s2_addr;
         r_fifo_tag[r_wr_ptr]    <= r_s2_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_drop_cnt <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push_ok && !w_pop)
            r_count <= r_count + 1'b1;
         else if (!w_push_ok && w_pop)
            r_count <= r_count - 1'b1;
         if (w_drop && r_drop_cnt != 16'hFFFF)
            r_drop_cnt <= r_drop_cnt + 16'd1;
         if (w_push_ok && r_s2_hit && r_hit_cnt != 16'hFFFF)
            r_hit_cnt <= r_hit_cnt + 16'd1;
         if (w_push_ok && !r_s2_hit && r_miss_cnt != 16'hFFFF)
            r_miss_cnt <= r_miss_cnt + 16'd1;
      end
   end

   // Head entry is forced to zero when empty so outputs are clean in reset.
   always_comb begin
      out_action = '0;
      out_hit    = 1'b0;
      out_addr   = '0;
      out_tag    = '0;
      if (out_valid) begin
         out_action = r_fifo_action[r_rd_ptr];
         out_hit    = r_fifo_hit[r_rd_ptr];
         out_addr   = r_fifo_addr[r_rd_ptr];
         out_tag    = r_fifo_tag[r_rd_ptr];
      end
   end

   // In-flight lookups are the one being presented now (S1) and the one in S2.
   always_comb begin
      w_used   = 32'(r_count) + 32'(in_valid) + 32'(r_s2_valid);
      in_ready = (w_used + 32'(SKID)) <= 32'(FIFO_DEPTH);
   end

   assign drop_cnt = r_drop_cnt;
   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pmt_action_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmt_action_fetch
// Purpose  : directed stimulus with a queue scoreboard for pmt_action_fetch.
// Revision : 1.0  initial release
// ============================================================================
module tb_pmt_action_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, match_found, in_ready;
   logic [4:0]  match_addr;
   logic [7:0]  in_tag;
   logic        cfg_wr_en, cfg_def_wr_en;
   logic [4:0]  cfg_wr_addr;
   logic [63:0] cfg_wr_data, cfg_def_data;
   logic        out_valid, out_ready, out_hit;
   logic [63:0] out_action;
   logic [4:0]  out_addr;
   logic [7:0]  out_tag;
   logic [15:0] drop_cnt, hit_cnt, miss_cnt;

   typedef struct {
      logic [63:0] act;
      logic        hit;
      logic [4:0]  addr;
      logic [7:0]  tag;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [63:0] ram_model [32];
   int          n_vec = 0;
   int          n_err = 0;
   logic        rdy;

   pmt_action_fetch dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .match_found(match_found), .match_addr(match_addr),
      .in_tag(in_tag), .in_ready(in_ready),
      .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
      .cfg_def_wr_en(cfg_def_wr_en), .cfg_def_data(cfg_def_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_action(out_action),
      .out_hit(out_hit), .out_addr(out_addr), .out_tag(out_tag),
      .drop_cnt(drop_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Every task starts and ends 1 time unit after a rising edge.
   task automatic cfg_write(input logic [4:0] a, input logic [63:0] d);
      cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
      @(posedge clk); #1;
      cfg_wr_en = 1'b0;
      ram_model[a] = d;
   endtask

   task automatic issue(input logic f, input logic [4:0] a, input logic [7:0] t,
                        input logic push_exp, input logic [63:0] exp_act,
                        output logic rdy_o);
      exp_t e;
      in_valid = 1'b1; match_found = f; match_addr = a; in_tag = t;
      if (push_exp) begin
         e.act = exp_act; e.hit = f; e.addr = f ? a : 5'd0; e.tag = t;
         exp_q.push_back(e);
      end
      #1 rdy_o = in_ready;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: head must match the oldest expectation; pop on handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else if (out_valid) begin
         if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_out: got tag %h action %h, expected no output", out_tag, out_action);
         end else begin
            mon_e = exp_q[0];
            chk("out_action", out_action, mon_e.act);
            chk("out_hit", 64'(out_hit), 64'(mon_e.hit));
            chk("out_addr", 64'(out_addr), 64'(mon_e.addr));
            chk("out_tag", 64'(out_tag), 64'(mon_e.tag));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; match_found = 1'b0; match_addr = '0; in_tag = '0;
      cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
      cfg_def_wr_en = 1'b0; cfg_def_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_action", out_action, 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_counters", {16'd0, drop_cnt, hit_cnt, miss_cnt}, 64'd0);
      rst_n = 1'b1;
      cycles(1);

      for (int i = 0; i < 8; i++) cfg_write(5'(i), 64'hC0FF_EE00_0000_0000 | 64'(i));
      cfg_write(5'd5, 64'hAAAA_AAAA_AAAA_AAAA);

      // Single hit, two-cycle latency
      out_ready = 1'b1;
      issue(1'b1, 5'd5, 8'h11, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, rdy);
      chk("lat_s2_out_valid", 64'(out_valid), 64'd0);
      cycles(1);
      chk("lat_out_valid", 64'(out_valid), 64'd1);
      cycles(1);
      chk("hit_cnt_1", 64'(hit_cnt), 64'd1);

      // Miss uses default, addr forced to 0
      cfg_def_wr_en = 1'b1; cfg_def_data = 64'h1234;
      cycles(1);
      cfg_def_wr_en = 1'b0;
      issue(1'b0, 5'd7, 8'h22, 1'b1, 64'h1234, rdy);
      cycles(2);
      chk("miss_cnt_1", 64'(miss_cnt), 64'd1);

      // Default written during S2 must not reach that entry
      issue(1'b0, 5'd2, 8'h23, 1'b1, 64'h1234, rdy);
      cfg_def_wr_en = 1'b1; cfg_def_data = 64'h5678;
      cycles(1);
      cfg_def_wr_en = 1'b0;
      issue(1'b0, 5'd2, 8'h24, 1'b1, 64'h5678, rdy);
      cycles(3);
      chk("miss_cnt_3", 64'(miss_cnt), 64'd3);

      // Read-first on same-cycle write
      cfg_wr_en = 1'b1; cfg_wr_addr = 5'd3; cfg_wr_data = 64'h3333_0000_0000_0333;
      issue(1'b1, 5'd3, 8'h30, 1'b1, 64'hC0FF_EE00_0000_0003, rdy);
      cfg_wr_en = 1'b0;
      ram_model[3] = 64'h3333_0000_0000_0333;
      issue(1'b1, 5'd3, 8'h31, 1'b1, 64'h3333_0000_0000_0333, rdy);
      cycles(3);
      chk("hit_cnt_3", 64'(hit_cnt), 64'd3);

      // Back-pressure: 6 lookups into a 4-deep FIFO
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         issue(1'b1, 5'(k), 8'h40 + 8'(k), k < 4, ram_model[k], rdy);
         chk($sformatf("in_ready_lookup%0d", k), 64'(rdy), (k == 0) ? 64'd1 : 64'd0);
      end
      cycles(2);
      chk("drop_cnt_2", 64'(drop_cnt), 64'd2);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("hit_cnt_7", 64'(hit_cnt), 64'd7);

      // Push and pop on the same edge while full
      issue(1'b1, 5'd6, 8'h50, 1'b1, ram_model[6], rdy);
      out_ready = 1'b1;
      cycles(1);
      out_ready = 1'b0;
      chk("pushpop_drop_cnt", 64'(drop_cnt), 64'd2);
      issue(1'b1, 5'd7, 8'h51, 1'b0, 64'd0, rdy);
      cycles(2);
      chk("still_full_drop_cnt", 64'(drop_cnt), 64'd3);
      chk("hit_cnt_8", 64'(hit_cnt), 64'd8);
      out_ready = 1'b1;
      cycles(8);
      chk("drained_out_valid", 64'(out_valid), 64'd0);
      chk("drained_queue", 64'(exp_q.size()), 64'd0);

      // Reset with 2 queued and 2 in flight
      out_ready = 1'b0;
      issue(1'b1, 5'd1, 8'h60, 1'b1, ram_model[1], rdy);
      issue(1'b1, 5'd2, 8'h61, 1'b1, ram_model[2], rdy);
      issue(1'b1, 5'd4, 8'h62, 1'b0, 64'd0, rdy);
      in_valid = 1'b1; match_found = 1'b1; match_addr = 5'd0; in_tag = 8'h63;
      #2;
      chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("async_rst_out_valid", 64'(out_valid), 64'd0);
      chk("async_rst_counters", {16'd0, drop_cnt, hit_cnt, miss_cnt}, 64'd0);
      cycles(2);
      rst_n = 1'b1;
      out_ready = 1'b1;
      cycles(6);
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);
      chk("post_rst_counters", {16'd0, drop_cnt, hit_cnt, miss_cnt}, 64'd0);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      // RAM survives reset
      issue(1'b1, 5'd5, 8'h70, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, rdy);
      cycles(3);
      chk("final_queue", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
